// File: rtl/pc_fetch_ctrl.sv
// Fetch PC controller with E-stage branch resolution, redirect/flush
// generation and saturating branch / mispredict performance counters.
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   stall_F                  hold the fetch PC
//   predict_valid_F/taken_F  fetch-stage predictor result for PC_F
//   predict_target_F         predicted target for PC_F
//   branch_resolved_E        conditional branch resolving in E
//   E_Jump, E_opcode         unconditional jump in E and its opcode
//   PC_E, branch_target_E    E instruction address and actual target
//   branch_taken_E           actual direction of the E branch
//   pred_taken_E/target_E    prediction carried with the E instruction
//   cnt_clr                  synchronous clear of both counters
//   PC_F, PC_plus4_F         fetch address and fetch address + 4
//   flush_D, flush_E         squash D and E on a redirect
//   mispredict_E             E-stage misprediction (combinational)
//   br_count, mispred_count  saturating resolve / mispredict counters
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_F,
  input  logic                 predict_taken_F,
  input  logic                 predict_valid_F,
  input  logic [31:0]          predict_target_F,
  input  logic                 branch_resolved_E,
  input  logic                 E_Jump,
  input  logic [6:0]           E_opcode,
  input  logic [31:0]          PC_E,
  input  logic [31:0]          branch_target_E,
  input  logic                 branch_taken_E,
  input  logic                 pred_taken_E,
  input  logic [31:0]          pred_target_E,
  input  logic                 cnt_clr,
  output logic [31:0]          PC_F,
  output logic [31:0]          PC_plus4_F,
  output logic                 flush_D,
  output logic                 flush_E,
  output logic                 mispredict_E,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispred_count
);

  localparam int unsigned PcWidth = 32;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PcWidth-1:0]   pc_q, pc_d;
  logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

  logic                 resolve_c;
  logic                 actual_taken_c;
  logic                 mispredict_c;
  logic [PcWidth-1:0]   correct_pc_c;
  logic [PcWidth-1:0]   pc_plus4_c;

  // JALR mismatches fall out of the generic target compare; opcode is not decoded.
  logic                 unused_opcode;
  assign unused_opcode = ^E_opcode;

  // E-stage resolution; only live in RUN so BOOT and the post-flush bubble are ignored.
  assign resolve_c      = (state_q == RUN) && (branch_resolved_E || E_Jump);
  assign actual_taken_c = branch_taken_E || E_Jump;
  assign mispredict_c   = resolve_c &&
                          ((actual_taken_c != pred_taken_E) ||
                           (actual_taken_c && (branch_target_E != pred_target_E)));
  assign correct_pc_c   = actual_taken_c ? branch_target_E : (PC_E + PcWidth'(4));
  assign pc_plus4_c     = pc_q + PcWidth'(4);

  // Next-state, next-PC and counter update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = mispredict_c ? RECOVER : RUN;
      RECOVER: state_d = RUN;
      default: state_d = BOOT;
    endcase

    // BOOT holds RESET_PC; redirect beats stall beats prediction beats +4.
    if (state_q != BOOT) begin
      if (mispredict_c) begin
        pc_d = correct_pc_c;
      end else if (stall_F) begin
        pc_d = pc_q;
      end else if (predict_valid_F && predict_taken_F) begin
        pc_d = predict_target_F;
      end else begin
        pc_d = pc_plus4_c;
      end
    end

    // Clear wins over increment; increments saturate at all-ones.
    if (cnt_clr) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else begin
      if (resolve_c && (br_cnt_q != '1)) begin
        br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
      end
      if (mispredict_c && (mis_cnt_q != '1)) begin
        mis_cnt_d = mis_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign PC_F          = pc_q;
  assign PC_plus4_F    = pc_plus4_c;
  assign mispredict_E  = mispredict_c;
  assign flush_D       = mispredict_c;
  assign flush_E       = mispredict_c;
  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl (4-bit counters to reach saturation).
module tb_pc_fetch_ctrl;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          stall_F;
  logic          predict_taken_F;
  logic          predict_valid_F;
  logic [31:0]   predict_target_F;
  logic          branch_resolved_E;
  logic          E_Jump;
  logic [6:0]    E_opcode;
  logic [31:0]   PC_E;
  logic [31:0]   branch_target_E;
  logic          branch_taken_E;
  logic          pred_taken_E;
  logic [31:0]   pred_target_E;
  logic          cnt_clr;
  logic [31:0]   PC_F;
  logic [31:0]   PC_plus4_F;
  logic          flush_D;
  logic          flush_E;
  logic          mispredict_E;
  logic [CW-1:0] br_count;
  logic [CW-1:0] mispred_count;

  int checks   = 0;
  int failures = 0;

  pc_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .CNT_WIDTH(CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_F          (stall_F),
    .predict_taken_F  (predict_taken_F),
    .predict_valid_F  (predict_valid_F),
    .predict_target_F (predict_target_F),
    .branch_resolved_E(branch_resolved_E),
    .E_Jump           (E_Jump),
    .E_opcode         (E_opcode),
    .PC_E             (PC_E),
    .branch_target_E  (branch_target_E),
    .branch_taken_E   (branch_taken_E),
    .pred_taken_E     (pred_taken_E),
    .pred_target_E    (pred_target_E),
    .cnt_clr          (cnt_clr),
    .PC_F             (PC_F),
    .PC_plus4_F       (PC_plus4_F),
    .flush_D          (flush_D),
    .flush_E          (flush_E),
    .mispredict_E     (mispredict_E),
    .br_count         (br_count),
    .mispred_count    (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_e();
    branch_resolved_E = 1'b0;
    E_Jump            = 1'b0;
    E_opcode          = 7'd0;
    PC_E              = 32'd0;
    branch_target_E   = 32'd0;
    branch_taken_E    = 1'b0;
    pred_taken_E      = 1'b0;
    pred_target_E     = 32'd0;
  endtask

  task automatic clear_f();
    stall_F          = 1'b0;
    predict_taken_F  = 1'b0;
    predict_valid_F  = 1'b0;
    predict_target_F = 32'd0;
  endtask

  // Taken branch predicted not-taken: always a mispredict when resolved in RUN.
  task automatic set_mispredict(input logic [31:0] tgt);
    branch_resolved_E = 1'b1;
    branch_taken_E    = 1'b1;
    branch_target_E   = tgt;
    pred_taken_E      = 1'b0;
    PC_E              = 32'h0000_0010;
  endtask

  initial begin
    rst     = 1'b0;
    cnt_clr = 1'b0;
    clear_e();
    clear_f();
    #2;
    chk("rst_pc",        PC_F, 32'h0);
    chk("rst_pc4",       PC_plus4_F, 32'h4);
    chk("rst_mispred",   32'(mispredict_E), 32'h0);
    chk("rst_flush",     32'({flush_D, flush_E}), 32'h0);
    chk("rst_brcnt",     32'(br_count), 32'h0);
    chk("rst_miscnt",    32'(mispred_count), 32'h0);

    // Release away from the edge; the BOOT cycle ignores a mismatching E branch.
    @(negedge clk);
    rst = 1'b1;
    set_mispredict(32'h0000_0500);
    #1;
    chk("boot_pc",       PC_F, 32'h0);
    chk("boot_mispred",  32'(mispredict_E), 32'h0);
    step();
    clear_e();
    #1;
    chk("run0_pc",       PC_F, 32'h0);
    chk("boot_brcnt",    32'(br_count), 32'h0);
    step();
    chk("run1_pc",       PC_F, 32'h4);
    step();
    chk("run2_pc",       PC_F, 32'h8);

    // Predicted-taken fetch redirects.
    predict_valid_F = 1'b1; predict_taken_F = 1'b1; predict_target_F = 32'h40;
    step();
    chk("pred_pc40",     PC_F, 32'h40);
    predict_target_F = 32'h100;
    step();
    chk("pred_pc100",    PC_F, 32'h100);
    chk("pred_brcnt",    32'(br_count), 32'h0);
    chk("pred_miscnt",   32'(mispred_count), 32'h0);

    // Valid but not-taken prediction is ignored.
    predict_taken_F = 1'b0;
    step();
    chk("pred_nt_pc",    PC_F, 32'h104);

    // PC+4 wraps at the top of the address space.
    predict_taken_F = 1'b1; predict_target_F = 32'hFFFF_FFFC;
    step();
    clear_f();
    #1;
    chk("wrap_pc4",      PC_plus4_F, 32'h0);
    step();
    chk("wrap_pc",       PC_F, 32'h0);

    // Not-taken mispredict under stall: redirect wins, PC_E+4.
    stall_F = 1'b1;
    PC_E = 32'h40; branch_resolved_E = 1'b1; pred_taken_E = 1'b1;
    pred_target_E = 32'h80; branch_taken_E = 1'b0; branch_target_E = 32'h80;
    #1;
    chk("mp_mispred",    32'(mispredict_E), 32'h1);
    chk("mp_flushD",     32'(flush_D), 32'h1);
    chk("mp_flushE",     32'(flush_E), 32'h1);
    step();
    chk("mp_pc",         PC_F, 32'h44);
    chk("mp_brcnt",      32'(br_count), 32'h1);
    chk("mp_miscnt",     32'(mispred_count), 32'h1);

    // RECOVER: spurious resolve ignored, stall still holds PC.
    #1;
    chk("rec_mispred",   32'(mispredict_E), 32'h0);
    chk("rec_flush",     32'({flush_D, flush_E}), 32'h0);
    step();
    chk("rec_pc_hold",   PC_F, 32'h44);
    chk("rec_brcnt",     32'(br_count), 32'h1);
    chk("rec_miscnt",    32'(mispred_count), 32'h1);
    clear_e();
    clear_f();

    // Correctly predicted taken branch: counted, no flush.
    branch_resolved_E = 1'b1; branch_taken_E = 1'b1; branch_target_E = 32'h300;
    pred_taken_E = 1'b1; pred_target_E = 32'h300; PC_E = 32'h20;
    #1;
    chk("ok_mispred",    32'(mispredict_E), 32'h0);
    step();
    chk("ok_pc",         PC_F, 32'h48);
    chk("ok_brcnt",      32'(br_count), 32'h2);
    chk("ok_miscnt",     32'(mispred_count), 32'h1);
    clear_e();

    // JALR with wrong predicted target.
    E_Jump = 1'b1; E_opcode = 7'b1100111; PC_E = 32'h60;
    pred_taken_E = 1'b1; pred_target_E = 32'h200; branch_target_E = 32'h204;
    #1;
    chk("jalr_mispred",  32'(mispredict_E), 32'h1);
    step();
    clear_e();
    #1;
    chk("jalr_pc",       PC_F, 32'h204);
    chk("jalr_brcnt",    32'(br_count), 32'h3);
    chk("jalr_miscnt",   32'(mispred_count), 32'h2);
    step();
    chk("jalr_rec_pc",   PC_F, 32'h208);

    // Drive mispredicts until both 4-bit counters saturate (br 3+13, mis 2+13).
    for (int i = 0; i < 13; i++) begin
      set_mispredict(32'h80);
      step();
      clear_e();
      step();
    end
    chk("sat_pre_miscnt", 32'(mispred_count), 32'hF);
    chk("sat_pre_brcnt",  32'(br_count), 32'hF);
    set_mispredict(32'h80);
    step();
    clear_e();
    #1;
    chk("sat_miscnt",    32'(mispred_count), 32'hF);
    chk("sat_brcnt",     32'(br_count), 32'hF);
    step();

    // Clear beats a simultaneous increment.
    set_mispredict(32'h90);
    cnt_clr = 1'b1;
    #1;
    chk("clr_mispred",   32'(mispredict_E), 32'h1);
    step();
    cnt_clr = 1'b0;
    clear_e();
    #1;
    chk("clr_miscnt",    32'(mispred_count), 32'h0);
    chk("clr_brcnt",     32'(br_count), 32'h0);
    chk("clr_pc",        PC_F, 32'h90);

    // Asynchronous reset mid-RECOVER with a resolve pending.
    stall_F = 1'b1;
    set_mispredict(32'hA0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pc",       PC_F, 32'h0);
    chk("arst_pc4",      PC_plus4_F, 32'h4);
    chk("arst_mispred",  32'(mispredict_E), 32'h0);
    step();
    chk("arst_hold_pc",  PC_F, 32'h0);
    chk("arst_brcnt",    32'(br_count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, the width of the performance counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall_F  input  1  hold the fetch PC.
REQ-006 SHALL have ports predict_taken_F / predict_valid_F  input  1 each, and predict_target_F  input  32: the fetch-stage predictor result for PC_F.
REQ-007 SHALL have ports branch_resolved_E  input  1  (conditional branch in E), E_Jump  input  1, and E_opcode  input  7.
REQ-008 SHALL have ports PC_E, branch_target_E  input  32, and branch_taken_E  input  1: the actual outcome in E.
REQ-009 SHALL have ports pred_taken_E  input  1 and pred_target_E  input  32: the prediction carried down the pipeline with the E instruction.
REQ-010 SHALL have port cnt_clr  input  1  synchronous clear of both counters.
REQ-011 SHALL have ports PC_F, PC_plus4_F  output  32  current fetch address and PC_F+4.
REQ-012 SHALL have ports flush_D, flush_E, mispredict_E  output  1 each.
REQ-013 SHALL have ports br_count, mispred_count  output  CNT_WIDTH.

Function
REQ-014 SHALL use a 3-state FSM: BOOT, RUN and RECOVER.
REQ-015 BOOT SHALL last exactly one cycle after reset release, keep PC_F = RESET_PC, ignore the predictor and E inputs, then go to RUN.
REQ-016 In E, resolve = state==RUN && (branch_resolved_E || E_Jump); actual_taken = branch_taken_E || E_Jump.
REQ-017 mispredict_E SHALL be combinational: resolve && (actual_taken != pred_taken_E || (actual_taken && branch_target_E != pred_target_E)).
REQ-018 The correct PC SHALL be branch_target_E when actual_taken, else PC_E+4 (mod 2^32).
REQ-019 The next-PC priority SHALL be: mispredict_E -> correct PC; else stall_F -> hold PC_F; else predict_valid_F && predict_taken_F -> predict_target_F; else PC_F+4.
REQ-020 A redirect SHALL override stall_F.
REQ-021 The PC+4 computation SHALL wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-022 flush_D and flush_E SHALL equal mispredict_E in the same cycle; the PC loads the redirect at the next edge, so the redirect penalty is 2 cycles.
REQ-023 On mispredict_E, the FSM SHALL go RUN -> RECOVER; RECOVER SHALL last one cycle, ignore the E inputs (the E slot holds a flushed bubble), then return to RUN.
REQ-024 In RECOVER, the fetch PC SHALL advance normally per REQ-019 (excluding the redirect term).
REQ-025 br_count SHALL increment by 1 on each resolve, and mispred_count by 1 on each mispredict_E.
REQ-026 Both counters SHALL saturate at all-ones.
REQ-027 cnt_clr SHALL zero both counters and take priority over an increment in the same cycle.
REQ-028 JAL/JALR SHALL count as resolves.
REQ-029 A JALR mismatch (E_opcode 7'b1100111) SHALL be a mispredict per REQ-017, with no special case.

Reset
REQ-030 While rst is low, the outputs SHALL be: PC_F = RESET_PC, PC_plus4_F = RESET_PC+4, flush_D = flush_E = mispredict_E = 0, both counters 0, state BOOT.
REQ-031 Assertion of rst SHALL take effect immediately, independent of clk, including mid-RECOVER or mid-stall.
REQ-032 Any pending redirect SHALL be discarded on reset.
REQ-033 Release of rst SHALL be sampled on the clock; the first edge after release completes BOOT.

Verification
REQ-034 Reset, then 4 free-running cycles with no prediction -> PC_F = 0, 0, 4, 8, with the first 0 being the BOOT cycle.
REQ-035 PC_F=0x40 with predict_valid_F=predict_taken_F=1 and target 0x100 -> next PC_F = 0x100; counters unchanged.
REQ-036 E branch at PC_E=0x40 with pred_taken_E=1, branch_taken_E=0 and stall_F=1 -> flush_D=flush_E=mispredict_E=1 that cycle; next PC_F=0x44; state RECOVER for one cycle; br_count=1, mispred_count=1.
REQ-037 E_Jump JALR predicted taken to 0x200, actual target 0x204 -> mispredict, next PC_F=0x204.
REQ-038 Mispredict in cycle N followed by a spurious branch_resolved_E in N+1 -> no second flush; counters increment only once.
REQ-039 Force mispred_count to all-ones, then another mispredict -> mispred_count holds all-ones; cnt_clr together with a mispredict -> 0. Then assert rst mid-RECOVER -> PC_F=RESET_PC immediately.
